// File: rtl/ysyx_25010008_ifu_if.sv
// rtl/ysyx_25010008_ifu_if.sv - AXI4-Lite-style instruction read channel
interface ysyx_25010008_ifu_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_25010008_ifu.sv
// rtl/ysyx_25010008_ifu.sv - multi-cycle instruction fetch unit, one read per instruction
// Optional perf counters enabled by defining YSYX_IFU_PERF_EN.
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_25010008_ifu_if.master  bus,
  output logic [31:0]          inst,
  output logic                 ivalid,
  output logic [31:0]          pc,
  input  logic                 wb_done,
  input  logic [31:0]          dnpc,
`ifdef YSYX_IFU_PERF_EN
  output logic [63:0]          perf_fetch_cnt,
  output logic [63:0]          perf_stall_cnt,
`endif
  output logic                 fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT_R = 2'd1,
    EXEC   = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        ivalid_q;
  logic        fetch_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      inst_q      <= NOP;
      ivalid_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      ivalid_q <= 1'b0;
      unique case (state_q)
        REQ: begin
          if (bus.arready) state_q <= WAIT_R;
        end
        WAIT_R: begin
          if (bus.rvalid) begin
            if (bus.rresp == 2'b00) begin
              inst_q   <= bus.rdata;
              ivalid_q <= 1'b1;
              state_q  <= EXEC;
            end else begin
              fetch_err_q <= 1'b1;
              state_q     <= ERR;
            end
          end
        end
        EXEC: begin
          if (wb_done) begin
            pc_q <= dnpc;
            if (dnpc[1:0] == 2'b00) begin
              state_q <= REQ;
            end else begin
              fetch_err_q <= 1'b1;
              state_q     <= ERR;
            end
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: state_q <= ERR;
      endcase
    end
  end

  // Bus strobes decode straight from the state flop so the first cycle after
  // release already requests; rst_n gating drops them the instant reset asserts.
  assign bus.arvalid = rst_n && (state_q == REQ);
  assign bus.rready  = rst_n && (state_q == WAIT_R);
  assign bus.araddr  = pc_q;

  assign inst      = inst_q;
  assign ivalid    = ivalid_q;
  assign pc        = pc_q;
  assign fetch_err = fetch_err_q;

`ifdef YSYX_IFU_PERF_EN
  logic [63:0] perf_fetch_q;
  logic [63:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 64'd0;
      perf_stall_q <= 64'd0;
    end else begin
      if (ivalid_q) perf_fetch_q <= perf_fetch_q + 64'd1;
      if (state_q == REQ || state_q == WAIT_R) perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// tb/tb_ysyx_25010008_ifu.sv - directed self-checking bench for the fetch unit
module tb_ysyx_25010008_ifu;
  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic        ivalid;
  logic [31:0] pc;
  logic        wb_done;
  logic [31:0] dnpc;
  logic        fetch_err;
`ifdef YSYX_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  ysyx_25010008_ifu_if bus ();

  ysyx_25010008_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .inst      (inst),
    .ivalid    (ivalid),
    .pc        (pc),
    .wb_done   (wb_done),
    .dnpc      (dnpc),
`ifdef YSYX_IFU_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .fetch_err (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    wb_done = 1'b0; dnpc = 32'h0;
    repeat (2) @(negedge clk);
    total_cnt++; if (pc !== 32'h8000_0000) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0000_0013) $display("FAIL reset_inst got=%h exp=%h", inst, 32'h13); else pass_cnt++;
    total_cnt++; if (ivalid !== 1'b0) $display("FAIL reset_ivalid got=%b exp=0", ivalid); else pass_cnt++;
    total_cnt++; if (bus.arvalid !== 1'b0) $display("FAIL reset_arvalid got=%b exp=0", bus.arvalid); else pass_cnt++;
    total_cnt++; if (bus.rready !== 1'b0) $display("FAIL reset_rready got=%b exp=0", bus.rready); else pass_cnt++;
    total_cnt++; if (fetch_err !== 1'b0) $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); else pass_cnt++;
    bus.arready = 1'b1;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.arvalid !== 1'b1) $display("FAIL first_arvalid got=%b exp=1", bus.arvalid); else pass_cnt++;
    total_cnt++; if (bus.araddr !== 32'h8000_0000) $display("FAIL first_araddr got=%h exp=%h", bus.araddr, 32'h8000_0000); else pass_cnt++;
  endtask

  task automatic test_basic_fetch();
    @(negedge clk);
    total_cnt++; if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0) $display("FAIL basic_wait_r rready=%b arvalid=%b exp 1/0", bus.rready, bus.arvalid); else pass_cnt++;
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0010_0093; bus.rresp = 2'b00;
    @(negedge clk);
    bus.rvalid = 1'b0;
    total_cnt++; if (ivalid !== 1'b1) $display("FAIL basic_ivalid got=%b exp=1", ivalid); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0010_0093) $display("FAIL basic_inst got=%h exp=%h", inst, 32'h0010_0093); else pass_cnt++;
    total_cnt++; if (pc !== 32'h8000_0000) $display("FAIL basic_pc got=%h exp=%h", pc, 32'h8000_0000); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ivalid !== 1'b0 || bus.arvalid !== 1'b0 || bus.rready !== 1'b0)
      $display("FAIL basic_exec_idle ivalid=%b arvalid=%b rready=%b exp 0/0/0", ivalid, bus.arvalid, bus.rready); else pass_cnt++;
  endtask

  task automatic test_commit();
    wb_done = 1'b1; dnpc = 32'h8000_0010;
    @(negedge clk);
    wb_done = 1'b0;
    total_cnt++; if (bus.arvalid !== 1'b1) $display("FAIL commit_arvalid got=%b exp=1", bus.arvalid); else pass_cnt++;
    total_cnt++; if (bus.araddr !== 32'h8000_0010) $display("FAIL commit_araddr got=%h exp=%h", bus.araddr, 32'h8000_0010); else pass_cnt++;
  endtask

  task automatic test_ar_stall();
    int bad = 0;
    int ivcnt = 0;
    int arcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0010) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL stall_ar_stable bad_cycles=%0d exp=0", bad); else pass_cnt++;
    // rvalid alongside the address handshake must not be taken as data
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b00;
    @(negedge clk);
    total_cnt++; if (bus.rready !== 1'b1 || ivalid !== 1'b0) $display("FAIL stall_early_rvalid rready=%b ivalid=%b exp 1/0", bus.rready, ivalid); else pass_cnt++;
    bus.arready = 1'b0; bus.rdata = 32'h0020_0113;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rvalid = 1'b0;
      if (ivalid === 1'b1) ivcnt++;
      if (bus.arvalid === 1'b1) arcnt++;
    end
    total_cnt++; if (ivcnt != 1) $display("FAIL stall_ivalid_count got=%0d exp=1", ivcnt); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0020_0113) $display("FAIL stall_inst got=%h exp=%h", inst, 32'h0020_0113); else pass_cnt++;
    total_cnt++; if (arcnt != 0) $display("FAIL stall_refetch got=%0d exp=0", arcnt); else pass_cnt++;
  endtask

  task automatic test_stray_wb();
    wb_done = 1'b1; dnpc = 32'h8000_0020;
    @(negedge clk);
    dnpc = 32'h1234_0000;
    @(negedge clk);
    wb_done = 1'b0;
    total_cnt++; if (bus.araddr !== 32'h8000_0020) $display("FAIL stray_wb_req got=%h exp=%h", bus.araddr, 32'h8000_0020); else pass_cnt++;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0; wb_done = 1'b1; dnpc = 32'h1234_0000;
    @(negedge clk);
    wb_done = 1'b0;
    total_cnt++; if (pc !== 32'h8000_0020 || bus.rready !== 1'b1) $display("FAIL stray_wb_wait pc=%h rready=%b exp %h/1", pc, bus.rready, 32'h8000_0020); else pass_cnt++;
    bus.rvalid = 1'b1; bus.rdata = 32'h0030_0193;
    @(negedge clk);
    bus.rvalid = 1'b0;
    total_cnt++; if (ivalid !== 1'b1 || inst !== 32'h0030_0193) $display("FAIL stray_wb_fetch ivalid=%b inst=%h exp 1/%h", ivalid, inst, 32'h0030_0193); else pass_cnt++;
    wb_done = 1'b1; dnpc = 32'h8000_0024;
    @(negedge clk);
    wb_done = 1'b0;
    total_cnt++; if (bus.araddr !== 32'h8000_0024 || bus.arvalid !== 1'b1) $display("FAIL stray_wb_next araddr=%h arvalid=%b exp %h/1", bus.araddr, bus.arvalid, 32'h8000_0024); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    total_cnt++; if (bus.rready !== 1'b1) $display("FAIL rstmid_in_wait rready=%b exp=1", bus.rready); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.rready !== 1'b0 || bus.arvalid !== 1'b0) $display("FAIL rstmid_drop rready=%b arvalid=%b exp 0/0", bus.rready, bus.arvalid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0000) $display("FAIL rstmid_refetch arvalid=%b araddr=%h exp 1/%h", bus.arvalid, bus.araddr, 32'h8000_0000); else pass_cnt++;
  endtask

  task automatic test_bus_err();
    int cnt = 0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rresp = 2'b10; bus.rdata = 32'hBADB_AD00;
    @(negedge clk);
    total_cnt++; if (fetch_err !== 1'b1) $display("FAIL buserr_flag got=%b exp=1", fetch_err); else pass_cnt++;
    total_cnt++; if (ivalid !== 1'b0 || inst !== 32'h0000_0013) $display("FAIL buserr_inst ivalid=%b inst=%h exp 0/%h", ivalid, inst, 32'h13); else pass_cnt++;
    bus.arready = 1'b1; bus.rresp = 2'b00; wb_done = 1'b1; dnpc = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.arvalid === 1'b1 || bus.rready === 1'b1 || ivalid === 1'b1) cnt++;
    end
    total_cnt++; if (cnt != 0 || fetch_err !== 1'b1) $display("FAIL buserr_halt active_cycles=%0d fetch_err=%b exp 0/1", cnt, fetch_err); else pass_cnt++;
    bus.arready = 1'b0; bus.rvalid = 1'b0; wb_done = 1'b0;
  endtask

  task automatic test_misaligned();
    int cnt = 0;
    rst_n = 1'b0;
    @(negedge clk);
    bus.arready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0040_0213; bus.rresp = 2'b00;
    @(negedge clk);
    bus.rvalid = 1'b0;
    total_cnt++; if (ivalid !== 1'b1 || fetch_err !== 1'b0) $display("FAIL misalign_fetch ivalid=%b fetch_err=%b exp 1/0", ivalid, fetch_err); else pass_cnt++;
    wb_done = 1'b1; dnpc = 32'h8000_0002;
    @(negedge clk);
    wb_done = 1'b0;
    total_cnt++; if (fetch_err !== 1'b1 || pc !== 32'h8000_0002) $display("FAIL misalign_flag fetch_err=%b pc=%h exp 1/%h", fetch_err, pc, 32'h8000_0002); else pass_cnt++;
    bus.arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.arvalid === 1'b1) cnt++;
    end
    total_cnt++; if (cnt != 0) $display("FAIL misalign_halt arvalid_cycles=%0d exp=0", cnt); else pass_cnt++;
    bus.arready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_commit();
    test_ar_stall();
    test_stray_wb();
    test_reset_mid();
    test_bus_err();
    test_misaligned();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
